// File: rtl/apb_clk_gate_sched.sv
// apb_clk_gate_sched: per-slave APB clock-gate scheduler.
// Each slave has its own OFF/WAKE/ON FSM. The FSM wakes the slave clock on
// demand, holds PREADY low until the clock has run WAKE_CYCLES, and gates the
// clock again after IDLE_CYCLES inactive cycles. In legacy mode the software
// enables drive the gates directly, and PREADY passes through without stalls.

package apb_clk_gate_sched_pkg;

    // Per-slave request: activity summary plus the raw inputs needed in legacy mode
    typedef struct packed {
        logic act;
        logic sw_en;
        logic pready_slv;
    } slot_req_t;

    // Per-slave response towards the bridge and the gating cell
    typedef struct packed {
        logic clk_en;
        logic pready;
        logic awake;
    } slot_rsp_t;

endpackage

// One slave's scheduler: state, counter and output muxing
module apb_clk_gate_slot
    import apb_clk_gate_sched_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      auto_en_i,
    input  slot_req_t req,
    output slot_rsp_t rsp
);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_WAKE = 2'd1,
        S_ON   = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] WAKE_LAST = CNT_WIDTH'(WAKE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] IDLE_LAST = CNT_WIDTH'(IDLE_CYCLES - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 en_q;     // clock enable as implied by the FSM state
    logic                 awake_q;  // FSM is in ON

    // FSM with counter; en_q/awake_q are updated alongside the state so they
    // always equal (state != OFF) and (state == ON)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= S_OFF;
            cnt     <= '0;
            en_q    <= 1'b0;
            awake_q <= 1'b0;
        end else if (!auto_en_i) begin
            // legacy: state tracks the software enable so auto mode can resume from it
            state   <= req.sw_en ? S_ON : S_OFF;
            cnt     <= '0;
            en_q    <= req.sw_en;
            awake_q <= req.sw_en;
        end else begin
            case (state)
                S_OFF: begin
                    if (req.act) begin
                        state <= S_WAKE;
                        cnt   <= '0;
                        en_q  <= 1'b1;
                    end
                end
                S_WAKE: begin
                    // activity is irrelevant here; the wake period always completes
                    if (cnt == WAKE_LAST) begin
                        state   <= S_ON;
                        cnt     <= '0;
                        awake_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ON: begin
                    // activity beats idle expiry in the same cycle
                    if (req.act) begin
                        cnt <= '0;
                    end else if (cnt == IDLE_LAST) begin
                        state   <= S_OFF;
                        cnt     <= '0;
                        en_q    <= 1'b0;
                        awake_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= S_OFF;
                    cnt     <= '0;
                    en_q    <= 1'b0;
                    awake_q <= 1'b0;
                end
            endcase
        end
    end

    // Output mux: legacy mode bypasses the FSM; reset forces everything low at once
    always_comb begin
        rsp = '0;
        if (!rst_i) begin
            rsp.awake = awake_q;
            if (auto_en_i) begin
                rsp.clk_en = en_q;
                rsp.pready = awake_q & req.pready_slv;
            end else begin
                rsp.clk_en = req.sw_en;
                rsp.pready = req.pready_slv;
            end
        end
    end

endmodule

module apb_clk_gate_sched
    import apb_clk_gate_sched_pkg::*;
#(
    parameter int NUM_SLAVES  = 8,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  auto_en_i,
    input  logic [NUM_SLAVES-1:0] sw_en_i,
    input  logic [NUM_SLAVES-1:0] busy_i,
    input  logic [NUM_SLAVES-1:0] psel_i,
    input  logic                  penable_i,
    input  logic [NUM_SLAVES-1:0] pready_slv_i,
    output logic [NUM_SLAVES-1:0] pready_o,
    output logic [NUM_SLAVES-1:0] clk_en_o,
    output logic [NUM_SLAVES-1:0] awake_o
);

    // PENABLE carries no information here: a held PSEL alone keeps the clock on
    logic unused_penable;
    assign unused_penable = penable_i;

    slot_req_t [NUM_SLAVES-1:0] req;
    slot_rsp_t [NUM_SLAVES-1:0] rsp;

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slot
        // Pack per-slave request and fan out the response bits
        always_comb begin
            req[i].act        = psel_i[i] | busy_i[i] | sw_en_i[i];
            req[i].sw_en      = sw_en_i[i];
            req[i].pready_slv = pready_slv_i[i];
            pready_o[i]       = rsp[i].pready;
            clk_en_o[i]       = rsp[i].clk_en;
            awake_o[i]        = rsp[i].awake;
        end

        apb_clk_gate_slot #(
            .IDLE_CYCLES (IDLE_CYCLES),
            .WAKE_CYCLES (WAKE_CYCLES),
            .CNT_WIDTH   (CNT_WIDTH)
        ) u_slot (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .auto_en_i (auto_en_i),
            .req       (req[i]),
            .rsp       (rsp[i])
        );
    end

endmodule

// File: tb/tb_apb_clk_gate_sched.sv
// tb_apb_clk_gate_sched: directed and randomized checks of the clock-gate
// scheduler against a cycle-level reference model of the slave lifecycle.

module tb_apb_clk_gate_sched;

    localparam int N    = 8;
    localparam int IDLE = 16;
    localparam int WAKE = 2;
    localparam int CW   = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         auto_en = 1'b0;
    logic [N-1:0] sw_en = '0;
    logic [N-1:0] busy = '0;
    logic [N-1:0] psel = '0;
    logic         penable = 1'b0;
    logic [N-1:0] pready_slv = '0;
    logic [N-1:0] pready;
    logic [N-1:0] clk_en;
    logic [N-1:0] awake;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: a slave is either off, waking with some cycles left, or on
    bit m_on   [N];
    int m_wake [N];
    int m_idle [N];

    // last sampled outputs
    logic [N-1:0] s_en, s_rdy, s_awk;

    apb_clk_gate_sched #(
        .NUM_SLAVES  (N),
        .IDLE_CYCLES (IDLE),
        .WAKE_CYCLES (WAKE),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .auto_en_i    (auto_en),
        .sw_en_i      (sw_en),
        .busy_i       (busy),
        .psel_i       (psel),
        .penable_i    (penable),
        .pready_slv_i (pready_slv),
        .pready_o     (pready),
        .clk_en_o     (clk_en),
        .awake_o      (awake)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_on[i]   = 1'b0;
            m_wake[i] = 0;
            m_idle[i] = 0;
        end
    endfunction

    // advance the model by one clock using the behavioural rules
    function automatic void m_step();
        for (int i = 0; i < N; i++) begin
            bit act;
            act = psel[i] | busy[i] | sw_en[i];
            if (!auto_en) begin
                m_on[i]   = sw_en[i];
                m_wake[i] = 0;
                m_idle[i] = 0;
            end else if (m_wake[i] > 0) begin
                m_wake[i]--;
                if (m_wake[i] == 0) begin
                    m_on[i]   = 1'b1;
                    m_idle[i] = 0;
                end
            end else if (m_on[i]) begin
                if (act) m_idle[i] = 0;
                else begin
                    m_idle[i]++;
                    if (m_idle[i] == IDLE) m_on[i] = 1'b0;
                end
            end else if (act) begin
                m_wake[i] = WAKE;
            end
        end
    endfunction

    // sample at negedge, compare with model, step model, return at posedge+1
    task automatic tick();
        logic [N-1:0] e_en, e_rdy, e_awk;
        @(negedge clk);
        s_en  = clk_en;
        s_rdy = pready;
        s_awk = awake;
        for (int i = 0; i < N; i++) begin
            e_awk[i] = m_on[i];
            if (auto_en) begin
                e_en[i]  = m_on[i] || (m_wake[i] > 0);
                e_rdy[i] = m_on[i] && pready_slv[i];
            end else begin
                e_en[i]  = sw_en[i];
                e_rdy[i] = pready_slv[i];
            end
        end
        chk("clk_en", 32'(s_en), 32'(e_en));
        chk("pready", 32'(s_rdy), 32'(e_rdy));
        chk("awake", 32'(s_awk), 32'(e_awk));
        m_step();
        @(posedge clk);
        #1;
    endtask

    // count cycles until pready_o[idx] first goes high (bounded)
    task automatic wake_latency(input int idx, output int lat, output int en_lat);
        lat    = -1;
        en_lat = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            tick();
            if (s_en[idx] && en_lat < 0) en_lat = k;
            if (s_rdy[idx]) lat = k;
        end
    endtask

    // count cycles clk_en_o[idx] stays high with no activity (bounded)
    task automatic count_high(input int idx, output int hi);
        hi = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (!s_en[idx]) break;
            hi++;
        end
    endtask

    initial begin
        int lat, en_lat, hi;
        m_reset();

        // reset state
        #2;
        chk("rst_en", 32'(clk_en), 32'h0);
        chk("rst_rdy", 32'(pready), 32'h0);
        chk("rst_awk", 32'(awake), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        auto_en = 1'b1;

        // quiet auto mode stays gated
        repeat (100) tick();
        chk("quiet_en", 32'(s_en), 32'h0);

        // on-demand wake of slave 3, zero-wait slave
        pready_slv = '1;
        psel[3] = 1'b1;
        penable = 1'b0;
        wake_latency(3, lat, en_lat);
        chk("wake_en_lat", 32'(en_lat), 32'd1);
        chk("wake_rdy_lat", 32'(lat), 32'(WAKE + 1));
        chk("wake_others", 32'(s_en & ~8'h08), 32'h0);

        // idle gating after the transfer ends
        penable = 1'b0;
        psel[3] = 1'b0;
        count_high(3, hi);
        chk("gate_lat", 32'(hi), 32'(IDLE));

        // re-assert at the expiry cycle: fresh idle count
        psel[3] = 1'b1;
        for (int k = 0; k < 10 && !s_awk[3]; k++) tick();
        tick();
        psel[3] = 1'b0;
        repeat (IDLE - 1) tick();
        psel[3] = 1'b1;
        tick();
        chk("rearm_on", 32'(s_awk[3]), 32'h1);
        psel[3] = 1'b0;
        count_high(3, hi);
        chk("rearm_gate", 32'(hi), 32'(IDLE));

        // force-on and periodic busy keep clocks running
        sw_en[1] = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            busy[5] = (k % 10 == 0);
            tick();
        end
        chk("force_on", 32'(s_en[1]), 32'h1);
        chk("busy_on", 32'(s_en[5]), 32'h1);
        busy = '0;
        sw_en[1] = 1'b0;
        count_high(1, hi);
        chk("force_drop", 32'(hi), 32'(IDLE));
        repeat (20) tick();

        // legacy static mode
        auto_en = 1'b0;
        sw_en = 8'hA5;
        pready_slv = 8'($urandom);
        tick();
        chk("legacy_en", 32'(s_en), 32'hA5);
        for (int k = 0; k < 50; k++) begin
            pready_slv = 8'($urandom);
            psel = 8'($urandom);
            tick();
        end
        psel = '0;

        // randomized mix of modes and activity
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
            else if ($urandom_range(0, 199) == 0) auto_en = 1'b1;
            psel       = 8'($urandom & $urandom & $urandom);
            busy       = 8'($urandom & $urandom & $urandom & $urandom);
            sw_en      = ($urandom_range(0, 49) == 0) ? 8'($urandom & $urandom) : sw_en;
            pready_slv = 8'($urandom);
            penable    = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                psel = '0;
                busy = '0;
            end
            tick();
        end

        // asynchronous reset with lower slaves ON and upper slaves in WAKE
        auto_en = 1'b1;
        sw_en = '0;
        busy = '0;
        pready_slv = '1;
        psel = 8'h0F;
        repeat (6) tick();
        psel = 8'hF0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_en", 32'(clk_en), 32'h0);
        chk("arst_rdy", 32'(pready), 32'h0);
        chk("arst_awk", 32'(awake), 32'h0);
        psel = '0;
        rst = 1'b0;
        m_reset();
        tick();
        psel[3] = 1'b1;
        wake_latency(3, lat, en_lat);
        chk("post_rst_lat", 32'(lat), 32'(WAKE + 1));
        psel = '0;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/apb_clk_gate_sched.md
Name: apb_clk_gate_sched

Overview:
- Per-slave clock-gate scheduler for the peripheral APB subsystem.
- Sits between the AXI2APB bridge, the APB slaves and the per-slave clock-gating cells.
- Wakes a slave's clock on demand when it is selected or busy, and stalls the APB transfer (PREADY low) until the clock is stable.
- Gates the clock again after a programmable idle period.
- Software force-on bits (pulpino control register) override auto-gating; a legacy mode reproduces static software gating.

Parameters:
NUM_SLAVES, 8, number of APB slaves / gated clocks
IDLE_CYCLES, 16, consecutive inactive cycles in ON before gating; legal range 1..2**CNT_WIDTH-1
WAKE_CYCLES, 2, cycles the clock runs in WAKE before transfers are released; legal range 1..2**CNT_WIDTH-1
CNT_WIDTH, 8, width of each per-slave counter

Ports:
clk_i  in  1  system clock (ungated)
rst_i  in  1  reset, asynchronous, active-high
auto_en_i  in  1  1 = auto-gating mode, 0 = legacy static mode
sw_en_i  in  NUM_SLAVES  software clock-enable / force-on per slave
busy_i  in  NUM_SLAVES  slave-internal activity (e.g. UART TX shifting); keeps clock on
psel_i  in  NUM_SLAVES  PSEL from bridge
penable_i  in  1  PENABLE from bridge
pready_slv_i  in  NUM_SLAVES  PREADY from slaves
pready_o  out  NUM_SLAVES  PREADY to bridge (stalled while clock not ready)
clk_en_o  out  NUM_SLAVES  enable to the per-slave clock-gating cell
awake_o  out  NUM_SLAVES  1 when the slave FSM is in ON (status)

Behaviour:
- Interface: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset, asynchronous and effective immediately, including mid-transfer: all FSMs OFF, all counters 0, clk_en_o = 0, pready_o = 0, awake_o = 0.
- One independent FSM and counter cnt[i] per slave i. States: OFF, WAKE, ON.
- act[i] = psel_i[i] | busy_i[i] | sw_en_i[i].

Auto mode (auto_en_i = 1):
- OFF:
  - clk_en = 0, pready_o = 0.
  - If act, go to WAKE next cycle with cnt = 0.
- WAKE:
  - clk_en = 1, pready_o = 0.
  - cnt increments each cycle.
  - When cnt == WAKE_CYCLES-1, go to ON next cycle with cnt = 0.
  - Activity is ignored in WAKE; WAKE always completes.
- ON:
  - clk_en = 1, awake = 1, pready_o[i] = pready_slv_i[i] (combinational).
  - If act, cnt = 0.
  - Else if cnt == IDLE_CYCLES-1, go to OFF next cycle.
  - Else cnt increments.
- Simultaneous activity and idle expiry in the same cycle: activity wins; stay ON, cnt = 0.
- psel_i held high never gates, regardless of penable_i. The bridge keeps PSEL/PENABLE asserted while pready_o is low, so a stalled transfer completes once ON is reached.
- Latency: psel rises in an OFF cycle t -> clk_en_o = 1 from t+1 -> ON from t+1+WAKE_CYCLES. The earliest pready_o is at t+1+WAKE_CYCLES when the slave is zero-wait.
- Gating latency: the last active cycle is a -> clk_en_o falls at a+IDLE_CYCLES+1.

Legacy mode (auto_en_i = 0):
- Each FSM is forced each cycle to ON if sw_en_i[i], else OFF; cnt = 0.
- clk_en_o = sw_en_i and pready_o = pready_slv_i, combinational, independent of state. No stall insertion, which matches the previous static behaviour.
- Switching auto_en_i 0 -> 1 continues from the forced state. Switching 1 -> 0 mid-WAKE takes effect the same cycle.

General:
- Counters never wrap: they are only compared against the thresholds and cleared.
- pslverr is not touched by this block.
- No cross-slave interaction: one slave waking or gating has no effect on the others.

Test Plan:
1. Reset, then auto_en = 1, all other inputs 0 -> clk_en_o = 0x00, pready_o = 0x00, awake_o = 0x00 for 100 cycles.
2. Wake: auto, WAKE_CYCLES = 2; psel_i[3] rises at t with pready_slv_i[3] = 1 -> clk_en_o[3] = 1 at t+1; pready_o[3] = 0 at t+1 and t+2; pready_o[3] = 1 at t+3; the other bits stay 0.
3. Idle gating: IDLE_CYCLES = 16; transfer ends at a, then no activity -> clk_en_o[3] = 1 through a+16 and 0 at a+17.
   - A repeat of this run with psel_i[3] re-asserted exactly at the expiry cycle -> stays ON, and a fresh 16-cycle count starts.
4. Force-on: sw_en_i[1] = 1 -> wakes (WAKE, then ON) and never gates over 1000 idle cycles.
   - With busy_i[5] pulsed every 10 cycles, slave 5 also never gates.
   - sw_en_i[1] -> 0 -> clk_en_o[1] = 0 at 17 cycles after the drop.
5. Legacy: auto_en = 0, sw_en_i = 0xA5 -> clk_en_o = 0xA5 immediately; pready_o = pready_slv_i bit-for-bit for random stimulus.
6. Reset mid-WAKE and mid-ON: rst_i pulsed asynchronously between clock edges -> all outputs 0 before the next edge. After release, a new psel gives the full WAKE latency again.
